// File: rtl/spi_mem_ctrl_if.sv
// Request/response bus between the CPU fetch/load-store unit and the serial SRAM controller.
// The CPU side is the master, the controller is the slave.
interface spi_mem_ctrl_if #(
    parameter int ADDR_W = 23
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              resp_valid;
    logic [15:0]       resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 master serving 16-bit word reads/writes against a 23LC-style serial SRAM.
// One 48-bit frame (opcode, 24-bit byte address, 16 data bits) per request, clk/2 bit rate.
module spi_mem_ctrl #(
    parameter int          ADDR_W    = 23,
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_mem_ctrl_if.slave   bus,
    output logic            spi_select,
    output logic            spi_clk,
    output logic            spi_mosi,
    input  logic            spi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t      state;
    logic [47:0] tx_sr;
    logic [15:0] rx_sr;
    logic [5:0]  bit_cnt;
    logic        phase_h;
    logic        is_write;

    // Byte address is the word address shifted left; no increment, so the top word ends at 0xFFFFFF.
    logic [23:0] byte_addr;
    logic [7:0]  cmd_byte;
    assign byte_addr = 24'({bus.req_addr, 1'b0});
    assign cmd_byte  = bus.req_write ? CMD_WRITE : CMD_READ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tx_sr          <= '0;
            rx_sr          <= '0;
            bit_cnt        <= '0;
            phase_h        <= 1'b0;
            is_write       <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            spi_select     <= 1'b0;
            spi_clk        <= 1'b0;
            spi_mosi       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        is_write      <= bus.req_write;
                        tx_sr         <= {cmd_byte, byte_addr,
                                          bus.req_write ? bus.req_wdata : 16'h0000};
                        spi_select    <= 1'b1;
                        spi_clk       <= 1'b0;
                        spi_mosi      <= cmd_byte[7];
                        bit_cnt       <= '0;
                        phase_h       <= 1'b0;
                        state         <= CMD;
                    end
                end
                CMD, ADDR, DATA: begin
                    if (!phase_h) begin
                        spi_clk <= 1'b1;
                        phase_h <= 1'b1;
                    end else begin
                        // End of phase H: sample MISO, drop the clock and present the next bit.
                        spi_clk <= 1'b0;
                        phase_h <= 1'b0;
                        rx_sr   <= {rx_sr[14:0], spi_miso};
                        tx_sr   <= {tx_sr[46:0], 1'b0};
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd47) begin
                            state          <= DONE;
                            spi_select     <= 1'b0;
                            spi_mosi       <= 1'b0;
                            bus.resp_valid <= 1'b1;
                            if (!is_write) begin
                                bus.resp_rdata <= {rx_sr[14:0], spi_miso};
                            end
                        end else begin
                            spi_mosi <= tx_sr[46];
                            if (bit_cnt == 6'd7) begin
                                state <= ADDR;
                            end else if (bit_cnt == 6'd31) begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DONE: begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    spi_select     <= 1'b0;
                    spi_clk        <= 1'b0;
                    spi_mosi       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: serial SRAM device model, protocol monitor, table vectors,
// randomized traffic against a byte-array reference, back-to-back and mid-frame reset sequences.
module tb_spi_mem_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_select, spi_clk, spi_mosi;
    logic spi_miso = 1'b0;

    spi_mem_ctrl_if #(.ADDR_W(23)) bus ();

    spi_mem_ctrl #(.ADDR_W(23)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .spi_select (spi_select),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Serial SRAM device model: samples MOSI on rising spi_clk, drives MISO after falling spi_clk.
    bit [7:0]    ram [int unsigned];
    bit [7:0]    ref_mem [int unsigned];
    int          s_cnt = 0;
    logic [7:0]  s_cmd = '0;
    logic [23:0] s_addr = '0;
    logic [15:0] s_wd = '0;
    logic [7:0]  last_cmd = '0;
    logic [23:0] last_addr = '0;

    always @(posedge spi_select) s_cnt = 0;

    always @(posedge spi_clk) begin
        if (s_cnt < 8)       s_cmd  = {s_cmd[6:0], spi_mosi};
        else if (s_cnt < 32) s_addr = {s_addr[22:0], spi_mosi};
        else if (s_cnt < 48) s_wd   = {s_wd[14:0], spi_mosi};
        s_cnt++;
        if (s_cnt == 32) begin
            last_cmd  = s_cmd;
            last_addr = s_addr;
        end
    end

    always @(negedge spi_clk) begin : dev_out
        logic [15:0] w;
        int unsigned a;
        if (spi_select && s_cnt >= 32 && s_cnt < 48 && s_cmd == 8'h03) begin
            a = 32'(s_addr);
            w = {ram[a], ram[a + 1]};
            spi_miso <= w[15 - (s_cnt - 32)];
        end
    end

    always @(negedge spi_select) begin : dev_commit
        int unsigned a;
        if (rst_n && s_cnt == 48 && s_cmd == 8'h02) begin
            a = 32'(s_addr);
            ram[a]     = s_wd[15:8];
            ram[a + 1] = s_wd[7:0];
        end
    end

    // Protocol monitor
    int   rise_cnt = 0;
    int   viol = 0;
    logic prev_mosi = 1'b0;
    always @(posedge spi_clk) rise_cnt++;
    always @(posedge spi_select) rise_cnt = 0;
    always @(negedge spi_select) if (rst_n) check("edges_per_frame", rise_cnt, 48);
    always @(negedge clk) begin
        if (spi_select !== 1'b1 && spi_clk === 1'b1) viol++;
        if (spi_clk === 1'b1 && spi_mosi !== prev_mosi) viol++;
        prev_mosi = spi_mosi;
    end

    task automatic preload(input int unsigned a, input bit [7:0] d);
        ram[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic do_txn(input logic wr, input logic [22:0] a, input logic [15:0] wd,
                          output logic [15:0] rd, output int lat);
        int  n;
        int  t;
        bit  got;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        t = 0;
        while (!bus.req_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) check("accept_timeout", 0, 1);
        n = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = 23'($urandom);
        bus.req_wdata = 16'($urandom);
        check("ready_low_in_frame", bus.req_ready, 0);
        got = 0;
        t = 0;
        while (!got && t < 200) begin
            if (bus.resp_valid) got = 1;
            else begin
                @(negedge clk);
                t++;
            end
        end
        check("resp_seen", got, 1);
        lat = cyc - n;
        rd  = bus.resp_rdata;
        @(negedge clk);
        check("resp_one_cycle", bus.resp_valid, 0);
        check("ready_after_done", bus.req_ready, 1);
    endtask

    typedef struct {
        logic        wr;
        logic [22:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic [7:0]  exp_cmd;
        logic [23:0] exp_baddr;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] rd;
        logic [15:0] exp;
        logic [15:0] last_rd;
        int          lat;

        vecs[0] = '{1'b0, 23'h000010, 16'h0000, 16'hABCD, 8'h03, 24'h000020};
        vecs[1] = '{1'b1, 23'h000100, 16'h1234, 16'hABCD, 8'h02, 24'h000200};
        vecs[2] = '{1'b0, 23'h000100, 16'h0000, 16'h1234, 8'h03, 24'h000200};
        vecs[3] = '{1'b0, 23'h7FFFFF, 16'h0000, 16'h5AC3, 8'h03, 24'hFFFFFE};
        vecs[4] = '{1'b1, 23'h7FFFFF, 16'hBEEF, 16'h5AC3, 8'h02, 24'hFFFFFE};
        vecs[5] = '{1'b0, 23'h000000, 16'h0000, 16'h9911, 8'h03, 24'h000000};

        preload(32'h20, 8'hAB);
        preload(32'h21, 8'hCD);
        preload(32'hFFFFFE, 8'h5A);
        preload(32'hFFFFFF, 8'hC3);
        preload(32'h0, 8'h99);
        preload(32'h1, 8'h11);

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_outputs", {spi_select, spi_clk, spi_mosi}, 3'b000);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, lat);
            $display("txn vec%0d wr=%0d addr=0x%06h wdata=0x%04h rdata=0x%04h lat=%0d",
                     i, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_latency", i), lat, 97);
            check($sformatf("vec%0d_cmd", i), last_cmd, vecs[i].exp_cmd);
            check($sformatf("vec%0d_byte_addr", i), last_addr, vecs[i].exp_baddr);
        end
        check("ram_200", ram[32'h200], 8'h12);
        check("ram_201", ram[32'h201], 8'h34);
        check("ram_fffffe", ram[32'hFFFFFE], 8'hBE);
        check("ram_ffffff", ram[32'hFFFFFF], 8'hEF);
        ref_mem[32'h200] = 8'h12;
        ref_mem[32'h201] = 8'h34;
        ref_mem[32'hFFFFFE] = 8'hBE;
        ref_mem[32'hFFFFFF] = 8'hEF;

        // Randomized traffic over a small word window, checked against the byte-array reference.
        for (int w = 32'h40; w < 32'h48; w++) begin
            preload(2 * w, 8'($urandom));
            preload(2 * w + 1, 8'($urandom));
        end
        last_rd = 16'h9911;
        for (int i = 0; i < 24; i++) begin
            logic        wr;
            logic [22:0] a;
            logic [15:0] wd;
            wr = 1'($urandom_range(0, 1));
            a  = 23'($urandom_range(32'h40, 32'h47));
            wd = 16'($urandom);
            do_txn(wr, a, wd, rd, lat);
            if (wr) begin
                ref_mem[2 * 32'(a)]     = wd[15:8];
                ref_mem[2 * 32'(a) + 1] = wd[7:0];
                exp = last_rd;
            end else begin
                exp = {ref_mem[2 * 32'(a)], ref_mem[2 * 32'(a) + 1]};
                last_rd = exp;
            end
            $display("txn rand%0d wr=%0d addr=0x%06h wdata=0x%04h rdata=0x%04h lat=%0d",
                     i, wr, a, wd, rd, lat);
            check($sformatf("rand%0d_rdata", i), rd, exp);
            check($sformatf("rand%0d_latency", i), lat, 97);
            check($sformatf("rand%0d_cmd", i), last_cmd, wr ? 8'h02 : 8'h03);
            check($sformatf("rand%0d_byte_addr", i), last_addr, {a, 1'b0});
        end

        // Back-to-back reads with req_valid held high.
        begin : b2b
            int acc = 0;
            int rsp = 0;
            int acc_cyc[2];
            int rsp_cyc[2];
            logic [15:0] rsp_rd[2];
            int busy_ready = 0;
            int gap = 0;
            bit switched = 0;
            acc_cyc = '{0, 0};
            rsp_cyc = '{0, 0};
            rsp_rd  = '{16'h0, 16'h0};
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_addr  = 23'h000010;
            for (int t = 0; t < 400 && rsp < 2; t++) begin
                if (t > 0) @(negedge clk);
                if (acc == 1 && !switched) begin
                    bus.req_addr = 23'h000100;
                    switched = 1;
                end
                if (acc == 2) bus.req_valid = 1'b0;
                if (bus.req_valid && bus.req_ready && acc < 2) begin
                    acc_cyc[acc] = cyc;
                    acc++;
                end
                if (bus.resp_valid && rsp < 2) begin
                    rsp_cyc[rsp] = cyc;
                    rsp_rd[rsp]  = bus.resp_rdata;
                    rsp++;
                end
                if (spi_select && bus.req_ready) busy_ready++;
                if (rsp == 1 && !spi_select) gap++;
            end
            bus.req_valid = 1'b0;
            $display("txn b2b accepts=%0d resps=%0d rd0=0x%04h rd1=0x%04h gap=%0d",
                     acc, rsp, rsp_rd[0], rsp_rd[1], gap);
            check("b2b_accepts", acc, 2);
            check("b2b_resps", rsp, 2);
            check("b2b_accept_spacing", acc_cyc[1] - acc_cyc[0], 98);
            check("b2b_first_latency", rsp_cyc[0] - acc_cyc[0], 97);
            check("b2b_rd0", rsp_rd[0], 16'hABCD);
            check("b2b_rd1", rsp_rd[1], 16'h1234);
            check("b2b_ready_low_busy", busy_ready, 0);
            check("b2b_select_gap", gap >= 1, 1);
            @(negedge clk);
        end

        // Reset asserted during the ADDR phase.
        begin : mid_reset
            int n;
            int t;
            int resp_seen = 0;
            int sel_seen = 0;
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_addr  = 23'h000100;
            t = 0;
            while (!bus.req_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            n = cyc;
            @(negedge clk);
            bus.req_valid = 1'b0;
            t = 0;
            while (cyc < n + 30 && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("mid_rst_select_before", spi_select, 1);
            rst_n = 1'b0;
            #1;
            check("mid_rst_select", spi_select, 0);
            check("mid_rst_clk", spi_clk, 0);
            check("mid_rst_ready", bus.req_ready, 1);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (bus.resp_valid) resp_seen++;
            end
            rst_n = 1'b1;
            for (int i = 0; i < 110; i++) begin
                @(negedge clk);
                if (bus.resp_valid) resp_seen++;
                if (spi_select) sel_seen++;
            end
            $display("txn mid_reset resp_seen=%0d select_seen=%0d", resp_seen, sel_seen);
            check("mid_rst_no_resp", resp_seen, 0);
            check("mid_rst_idle_after", sel_seen, 0);
            check("mid_rst_rdata_cleared", bus.resp_rdata, 0);
            do_txn(1'b0, 23'h000100, 16'h0000, rd, lat);
            $display("txn post_reset addr=0x000100 rdata=0x%04h lat=%0d", rd, lat);
            check("post_rst_rdata", rd, 16'h1234);
            check("post_rst_latency", lat, 97);
            check("post_rst_byte_addr", last_addr, 24'h000200);
        end

        check("protocol_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
